// File: rtl/adder_accum_ctrl_pkg.sv
// Shared types for the serial accumulate controller.
// Holds the FSM state encoding and the operand counter width helper.
package adder_accum_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Wide enough to hold NUM_IN itself, not just NUM_IN-1.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/adder_accum_ctrl_if.sv
// Operand handshake bundle: op_valid/op_data/op_sub from the producer,
// op_ready back from the controller (slave = controller side).
interface adder_accum_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             op_valid;
    logic [WIDTH-1:0] op_data;
    logic             op_sub;
    logic             op_ready;

    modport master (
        output op_valid,
        output op_data,
        output op_sub,
        input  op_ready
    );

    modport slave (
        input  op_valid,
        input  op_data,
        input  op_sub,
        output op_ready
    );
endinterface

// File: rtl/Adder.sv
// WIDTH-bit ripple-carry adder, s = a + b + cin modulo 2^WIDTH.
// Ports: a, b operands; cin carry in; s sum (carry-out not exposed).
module Adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s
);

    logic c;

    always_comb begin
        c = cin;
        s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/adder_accum_ctrl.sv
// Serial accumulator: one shared Adder adds/subtracts NUM_IN operands.
// Ports: clk, rst (sync, active-low), start, op (operand handshake),
// busy, done (1-cycle pulse), sum (= acc), ovf (sticky signed overflow).
module adder_accum_ctrl
    import adder_accum_ctrl_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    adder_accum_ctrl_if.slave         op,
    output logic                      busy,
    output logic                      done,
    output logic [WIDTH-1:0]          sum,
    output logic                      ovf
);

    localparam int CNT_W = cnt_width(NUM_IN);

    state_t           st;
    state_t           st_n;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] add_s;
    logic [CNT_W-1:0] cnt;
    logic             ovf_r;
    logic             hs;
    logic             last;
    logic             step_ovf;

    // Subtraction is a + ~b + 1 through the same adder.
    assign b_eff = op.op_sub ? ~op.op_data : op.op_data;

    Adder #(.WIDTH(WIDTH)) u_add (
        .a   (acc),
        .b   (b_eff),
        .cin (op.op_sub),
        .s   (add_s)
    );

    assign hs   = op.op_valid & op.op_ready;
    assign last = (cnt == CNT_W'(NUM_IN - 1));

    // Like-signed inputs producing an opposite-signed result.
    assign step_ovf = (acc[WIDTH-1] == b_eff[WIDTH-1]) &&
                      (add_s[WIDTH-1] != acc[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            st    <= ST_IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf_r <= 1'b0;
        end else begin
            st <= st_n;
            if (st == ST_IDLE && start) begin
                acc   <= '0;
                cnt   <= '0;
                ovf_r <= 1'b0;
            end else if (hs) begin
                acc <= add_s;
                cnt <= cnt + CNT_W'(1);
                if (step_ovf) begin
                    ovf_r <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        st_n        = st;
        op.op_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (st)
            ST_IDLE: begin
                if (start) begin
                    st_n = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                op.op_ready = 1'b1;
                busy        = 1'b1;
                if (hs && last) begin
                    st_n = ST_DONE;
                end
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
                st_n = ST_IDLE;
            end
            default: begin
                st_n = ST_IDLE;
            end
        endcase
    end

    assign sum = acc;
    assign ovf = ovf_r;

endmodule

// File: tb/tb_adder_accum_ctrl.sv
// Self-checking bench for adder_accum_ctrl (NUM_IN=4 and NUM_IN=1 builds).
// Directed table vectors, corner sequences and randomized runs vs a model.
module tb_adder_accum_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       ovf;
    logic       start1;
    logic       busy1;
    logic       done1;
    logic [7:0] sum1;
    logic       ovf1;

    always #5 clk = ~clk;

    adder_accum_ctrl_if #(.WIDTH(8)) bus ();
    adder_accum_ctrl_if #(.WIDTH(8)) bus1 ();

    adder_accum_ctrl #(.WIDTH(8), .NUM_IN(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (bus.slave),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .ovf   (ovf)
    );

    adder_accum_ctrl #(.WIDTH(8), .NUM_IN(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .op    (bus1.slave),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .ovf   (ovf1)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]      subs;
        logic [3:0][7:0] data;
        logic [7:0]      esum;
        logic            eovf;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Signed running total in plain integers; overflow = leaves 8-bit range.
    function automatic void model(input logic [3:0] subs,
                                  input logic [3:0][7:0] data,
                                  output logic [7:0] s, output logic o);
        int a;
        int x;
        int r;
        logic [7:0] w;
        a = 0;
        o = 1'b0;
        for (int i = 0; i < 4; i++) begin
            x = int'($signed(data[i]));
            r = subs[i] ? a - x : a + x;
            if (r > 127 || r < -128) o = 1'b1;
            w = 8'(r);
            a = int'($signed(w));
        end
        s = 8'(a);
    endfunction

    task automatic run4(input string nm, input logic [3:0] subs,
                        input logic [3:0][7:0] data, input int gap,
                        input bit poke, input logic [7:0] es,
                        input logic eo);
        start = 1'b1;
        tick();
        start = poke;
        chk({nm, " ready"}, 32'(bus.op_ready), 32'd1);
        chk({nm, " busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap; g++) begin
                bus.op_valid = 1'b0;
                tick();
            end
            chk({nm, " early done"}, 32'(done), 32'd0);
            bus.op_valid = 1'b1;
            bus.op_data  = data[i];
            bus.op_sub   = subs[i];
            tick();
        end
        bus.op_valid = 1'b0;
        chk({nm, " done"}, 32'(done), 32'd1);
        chk({nm, " ready@done"}, 32'(bus.op_ready), 32'd0);
        chk({nm, " sum"}, 32'(sum), 32'(es));
        chk({nm, " ovf"}, 32'(ovf), 32'(eo));
        tick();
        start = 1'b0;
        chk({nm, " done pulse"}, 32'(done), 32'd0);
        chk({nm, " idle busy"}, 32'(busy), 32'd0);
        chk({nm, " sum hold"}, 32'(sum), 32'(es));
    endtask

    initial begin
        logic [3:0]      rs;
        logic [3:0][7:0] rd;
        logic [7:0]      ms;
        logic            mo;

        tbl[0] = '{4'b0000, {8'd9, 8'd7, 8'd5, 8'd3}, 8'h18, 1'b0};
        tbl[1] = '{4'b0110, {8'd1, 8'd4, 8'd3, 8'd10}, 8'h04, 1'b0};
        tbl[2] = '{4'b0010, {8'd0, 8'd0, 8'd5, 8'd0}, 8'hFB, 1'b0};
        tbl[3] = '{4'b0100, {8'd0, 8'd20, 8'd50, 8'd100}, 8'h82, 1'b1};
        tbl[4] = '{4'b0000, {8'd1, 8'd1, 8'd1, 8'd1}, 8'h04, 1'b0};

        rst           = 1'b0;
        start         = 1'b0;
        bus.op_valid  = 1'b0;
        bus.op_data   = '0;
        bus.op_sub    = 1'b0;
        start1        = 1'b0;
        bus1.op_valid = 1'b0;
        bus1.op_data  = '0;
        bus1.op_sub   = 1'b0;
        tick();
        tick();
        chk("rst sum", 32'(sum), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst ready", 32'(bus.op_ready), 32'd0);
        chk("rst ovf", 32'(ovf), 32'd0);
        rst = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            run4($sformatf("vec%0d", v), tbl[v].subs, tbl[v].data, 0, 1'b0,
                 tbl[v].esum, tbl[v].eovf);
        end

        run4("gaps", 4'b0000, {8'd4, 8'd3, 8'd2, 8'd1}, 2, 1'b0,
             8'd10, 1'b0);
        run4("poke", 4'b0000, {8'd9, 8'd7, 8'd5, 8'd3}, 0, 1'b1,
             8'h18, 1'b0);

        // Reset in the middle of a run.
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.op_valid = 1'b1;
        bus.op_sub   = 1'b0;
        bus.op_data  = 8'd7;
        tick();
        bus.op_data  = 8'd9;
        tick();
        rst = 1'b0;
        tick();
        chk("midrst sum", 32'(sum), 32'd0);
        chk("midrst ready", 32'(bus.op_ready), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        rst = 1'b1;
        bus.op_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst no done", 32'(done), 32'd0);
            chk("midrst stays idle", 32'(busy), 32'd0);
        end

        for (int n = 0; n < 20; n++) begin
            rs = 4'($urandom);
            for (int i = 0; i < 4; i++) rd[i] = 8'($urandom);
            model(rs, rd, ms, mo);
            run4($sformatf("rnd%0d", n), rs, rd, int'($urandom_range(0, 2)),
                 1'b0, ms, mo);
        end

        // NUM_IN=1 build.
        start1        = 1'b1;
        bus1.op_valid = 1'b1;
        bus1.op_data  = 8'h7F;
        bus1.op_sub   = 1'b0;
        tick();
        start1 = 1'b0;
        chk("n1 ready", 32'(bus1.op_ready), 32'd1);
        chk("n1 early done", 32'(done1), 32'd0);
        tick();
        chk("n1 done", 32'(done1), 32'd1);
        chk("n1 sum", 32'(sum1), 32'h7F);
        chk("n1 ovf", 32'(ovf1), 32'd0);
        bus1.op_valid = 1'b0;
        tick();
        chk("n1 idle", 32'(busy1), 32'd0);
        start1        = 1'b1;
        bus1.op_valid = 1'b1;
        bus1.op_data  = 8'h80;
        bus1.op_sub   = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        bus1.op_valid = 1'b0;
        chk("n1 sub done", 32'(done1), 32'd1);
        chk("n1 sub sum", 32'(sum1), 32'h80);
        chk("n1 sub ovf", 32'(ovf1), 32'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_accum_ctrl.md
Name: adder_accum_ctrl

Overview:
Sequencer that time-shares one WIDTH-bit ripple `Adder` to accumulate NUM_IN signed operands serially, one per accepted handshake. Per operand, the accumulator either adds it or subtracts it (b inverted, cin=1).
Serves the MaxNet neuron update path, e.g. a_i minus the inhibition terms, with one adder instead of a tree.
Reports the final sum with a one-cycle done pulse and a sticky two's-complement overflow flag.

Parameters:
WIDTH, 8, operand/accumulator width in bits (two's complement)
NUM_IN, 4, operands per accumulation run; must be >= 1
CNT_W, $clog2(NUM_IN)+1, operand counter width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-low reset
start  input  1  begin a new run; honoured only in IDLE
op_valid  input  1  operand present on op_data/op_sub
op_data  input  WIDTH  operand value
op_sub  input  1  1 = subtract this operand, 0 = add; sampled with op_data
op_ready  output  1  controller accepts an operand this cycle
busy  output  1  run in progress (ACCUM or DONE)
done  output  1  single-cycle pulse: sum final
sum  output  WIDTH  accumulator value; holds after done until next start
ovf  output  1  sticky signed overflow for the current run

Behaviour:
- Reset (rst=0 at a rising edge): state=IDLE, acc=0, cnt=0, op_ready=0, busy=0, done=0, ovf=0. Reset wins over all other inputs in the same cycle, including mid-run.
- States: IDLE, ACCUM, DONE. All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- IDLE, start=1 -> ACCUM next cycle, with acc<=0, cnt<=0, ovf<=0. op_ready=0 and busy=0 while in IDLE.
- ACCUM: op_ready=1 and busy=1.
  - Handshake = op_valid & op_ready.
  - On handshake: acc <= Adder(a=acc, b=op_sub ? ~op_data : op_data, cin=op_sub), and cnt <= cnt+1.
  - No handshake: acc and cnt hold. Gaps in op_valid are legal.
  - Handshake with cnt == NUM_IN-1 -> DONE.
- DONE: done=1 and busy=1 for exactly one cycle, op_ready=0 -> IDLE.
- start is ignored while in ACCUM or DONE; no queuing.
- Arithmetic is modulo 2^WIDTH; no saturation, carry-out discarded.
- ovf: set when sign(a) == sign(b_eff) and sign(result) != sign(a), where b_eff is the Adder b input. Once set it stays set until the next accepted start or reset.
- sum = acc at all times. It is valid to consumers on the done cycle and holds until the next start clears it.
- Latency: with op_valid held high, start at cycle 0 gives op_ready at cycle 1, the last handshake at cycle NUM_IN, and done at cycle NUM_IN+1. Next start is accepted at cycle NUM_IN+2.
- NUM_IN=1: a single handshake goes straight to DONE.
- Adder usage: a/b/cin are driven only from acc, op_data and op_sub. The result is written only on handshake, so the adder output is a don't-care otherwise.

Decomposition:
- Shared package/header: state encodings ST_IDLE/ST_ACCUM/ST_DONE (2-bit) and the CNT_W derivation.
- Sub-module: one instance of the existing `Adder` #(WIDTH). The controller contains only the FSM, counter, acc register, operand inversion and ovf logic.

Test Plan:
- WIDTH=8, NUM_IN=4; start, then add 3,5,7,9 back-to-back -> done at cycle 5, sum=24 (0x18), ovf=0, op_ready low on cycle 5.
- Mixed op: add 10, sub 3, sub 4, add 1 -> sum=4; then add 0, sub 5, add 0, add 0 -> sum=0xFB (-5), ovf=0.
- Overflow: add 100, add 50, sub 20, add 0 -> sum=130 as 0x82, ovf=1 and stays 1 through done. A following run of add 1 x4 -> ovf=0, sum=4.
- Valid gaps: operands 1,2,3,4 with op_valid low for 2 cycles between each -> cnt advances only on handshakes, done exactly one cycle after the 4th handshake, sum=10.
- start pulsed during ACCUM and on the DONE cycle -> ignored, run result unchanged. rst=0 for one cycle after 2 operands -> next cycle state IDLE, sum=0, op_ready=0, busy=0, done never pulses.
- NUM_IN=1 build: start, add 0x7F -> done 2 cycles after start, sum=0x7F. Sub 0x80 from 0 -> sum=0x80, ovf=1.
